// File: rtl/fp16_stream_acc.sv
`default_nettype none
// ============================================================================
// Module      : fp16_stream_acc
// Description : Sequential binary16 group accumulator. It sums a stream of
//               products, one every four cycles, rounding each addition to
//               nearest-even. Each group ends with a last flag, and the block
//               then presents the group sum with its OR-ed IEEE status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_stream_acc #(
   parameter logic [15:0] CANON_NAN = 16'h7E00
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [15:0] in_data_i,
   input  logic        in_last_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] out_data_o,
   output logic [4:0]  out_status_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      NORM  = 3'd3,
      OUT   = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   // Group state: running sum, OR-ed flags {NV, DZ, OF, UF, NX}, and the
   // latched operand.
   logic [15:0] acc;
   logic [4:0]  status;
   logic [15:0] operand;
   logic        last_flag;

   // Registers between the ALIGN and ADD stages.
   logic [13:0] big_sig;
   logic [13:0] small_sig;
   logic [4:0]  big_exp;
   logic        res_sign;
   logic        eff_sub;
   logic        spec_hit;
   logic [15:0] spec_val;
   logic        spec_nv;

   // Register between the ADD and NORM stages; bit 14 is the carry-out.
   logic [14:0] sum;

   logic accept;
   logic drain;

   // ------------------------------------------------------------------------
   // Alignment: classify, order by magnitude, shift the smaller operand.
   // ------------------------------------------------------------------------
   logic        a_nan, x_nan, a_snan, x_snan, a_inf, x_inf, inf_clash;
   logic        swap;
   logic [15:0] op_big, op_small;
   logic [4:0]  e_big, e_small, exp_diff;
   logic [3:0]  shamt;
   logic [27:0] shift_full;
   logic [13:0] sig_big_w, sig_small_w;
   logic        spec_hit_w, spec_nv_w;
   logic [15:0] spec_val_w;

   // Unpack acc and operand. Subnormals take exponent 1 with no hidden bit.
   // Shifts of 14 or more push the whole significand into sticky.
   always_comb begin
      a_nan      = (acc[14:10] == 5'h1F) && (acc[9:0] != 10'd0);
      x_nan      = (operand[14:10] == 5'h1F) && (operand[9:0] != 10'd0);
      a_snan     = a_nan && !acc[9];
      x_snan     = x_nan && !operand[9];
      a_inf      = (acc[14:10] == 5'h1F) && (acc[9:0] == 10'd0);
      x_inf      = (operand[14:10] == 5'h1F) && (operand[9:0] == 10'd0);
      inf_clash  = a_inf && x_inf && (acc[15] ^ operand[15]);

      spec_hit_w = a_nan || x_nan || a_inf || x_inf;
      spec_nv_w  = a_snan || x_snan || inf_clash;
      if (a_nan || x_nan || inf_clash) begin
         spec_val_w = CANON_NAN;
      end else if (a_inf) begin
         spec_val_w = acc;
      end else begin
         spec_val_w = operand;
      end

      // For finite values the magnitude order is the integer order of
      // bits [14:0], so the larger one can be found without unpacking.
      swap     = operand[14:0] > acc[14:0];
      op_big   = swap ? operand : acc;
      op_small = swap ? acc : operand;

      e_big    = (op_big[14:10] == 5'd0) ? 5'd1 : op_big[14:10];
      e_small  = (op_small[14:10] == 5'd0) ? 5'd1 : op_small[14:10];
      exp_diff = e_big - e_small;
      shamt    = (exp_diff > 5'd14) ? 4'd14 : exp_diff[3:0];

      sig_big_w   = {(op_big[14:10] != 5'd0), op_big[9:0], 3'b000};
      shift_full  = {(op_small[14:10] != 5'd0), op_small[9:0], 17'd0} >> shamt;
      sig_small_w = {shift_full[27:15], shift_full[14] | (|shift_full[13:0])};
   end

   // ------------------------------------------------------------------------
   // Normalization, rounding and packing of the raw sum.
   // ------------------------------------------------------------------------
   logic [3:0]  lz;
   logic [4:0]  max_shift, shift_amt;
   logic [13:0] norm_sig;
   logic [5:0]  norm_exp;
   logic        round_up, inexact;
   logic [11:0] mant_rnd;
   logic [10:0] final_mant;
   logic [5:0]  final_exp;
   logic [15:0] norm_result;
   logic [4:0]  norm_flags;

   // Left shifts stop at exponent 1, which makes tiny results subnormal.
   // A carry-out shifts right once and keeps the lost bit in sticky.
   always_comb begin
      lz = 4'd14;
      for (int i = 0; i < 14; i++) begin
         if (sum[i]) begin
            lz = 4'(13 - i);
         end
      end

      max_shift = big_exp - 5'd1;
      shift_amt = 5'd0;
      if (sum[14]) begin
         norm_sig = {sum[14:2], sum[1] | sum[0]};
         norm_exp = {1'b0, big_exp} + 6'd1;
      end else begin
         shift_amt = ({1'b0, lz} > max_shift) ? max_shift : {1'b0, lz};
         norm_sig  = sum[13:0] << shift_amt;
         norm_exp  = {1'b0, big_exp} - {1'b0, shift_amt};
      end

      // Round to nearest, ties to even, on guard / round / sticky.
      inexact  = |norm_sig[2:0];
      round_up = norm_sig[2] && (norm_sig[1] || norm_sig[0] || norm_sig[3]);
      mant_rnd = {1'b0, norm_sig[13:3]} + {11'd0, round_up};
      if (mant_rnd[11]) begin
         final_mant = mant_rnd[11:1];
         final_exp  = norm_exp + 6'd1;
      end else begin
         final_mant = mant_rnd[10:0];
         final_exp  = norm_exp;
      end

      if (spec_hit) begin
         norm_result = spec_val;
         norm_flags  = {spec_nv, 4'b0000};
      end else if (sum == 15'd0) begin
         // Exact cancellation and sums of zeros always give +0.
         norm_result = 16'h0000;
         norm_flags  = 5'b00000;
      end else if (final_exp >= 6'd31) begin
         norm_result = {res_sign, 5'h1F, 10'd0};
         norm_flags  = 5'b00101;
      end else begin
         norm_result = {res_sign, (final_mant[10] ? final_exp[4:0] : 5'd0),
                        final_mant[9:0]};
         norm_flags  = {3'b000, inexact && !final_mant[10], inexact};
      end
   end

   // ------------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------------
   assign accept = in_valid_i && in_ready_o;
   assign drain  = out_valid_o && out_ready_i;

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. Ready is masked while reset is held.
   always_comb begin
      state_next  = state;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b1;
      case (state)
         IDLE: begin
            busy_o     = 1'b0;
            in_ready_o = rst_ni;
            if (in_valid_i && rst_ni) begin
               state_next = ALIGN;
            end
         end
         ALIGN: state_next = ADD;
         ADD:   state_next = NORM;
         NORM:  state_next = last_flag ? OUT : IDLE;
         OUT: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers, each loaded in its own FSM state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc       <= 16'h0000;
         status    <= 5'b00000;
         operand   <= 16'h0000;
         last_flag <= 1'b0;
         big_sig   <= 14'd0;
         small_sig <= 14'd0;
         big_exp   <= 5'd0;
         res_sign  <= 1'b0;
         eff_sub   <= 1'b0;
         spec_hit  <= 1'b0;
         spec_val  <= 16'h0000;
         spec_nv   <= 1'b0;
         sum       <= 15'd0;
      end else begin
         if (accept) begin
            operand   <= in_data_i;
            last_flag <= in_last_i;
         end
         if (state == ALIGN) begin
            big_sig   <= sig_big_w;
            small_sig <= sig_small_w;
            big_exp   <= e_big;
            res_sign  <= op_big[15];
            eff_sub   <= op_big[15] ^ op_small[15];
            spec_hit  <= spec_hit_w;
            spec_val  <= spec_val_w;
            spec_nv   <= spec_nv_w;
         end
         if (state == ADD) begin
            sum <= eff_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                           : ({1'b0, big_sig} + {1'b0, small_sig});
         end
         if (state == NORM) begin
            acc    <= norm_result;
            status <= status | norm_flags;
         end
         if (drain) begin
            acc    <= 16'h0000;
            status <= 5'b00000;
         end
      end
   end

   assign out_data_o   = acc;
   assign out_status_o = status;

endmodule
`default_nettype wire
